// File: rtl/telemetry_pkg.sv
// Shared types and constants for the telemetry framer: FSM states, frame geometry, byte builder.
package telemetry_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        LOAD,
        START,
        WAIT_DONE,
        NEXT
    } state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         FRAME_BYTES    = 7;
    localparam int         RPM_W          = 9;
    localparam int         DUTY_W         = 16;

    // Byte idx of one channel frame; the checksum covers everything after the header.
    function automatic logic [7:0] frame_byte(
        input logic [7:0]        hdr,
        input logic [7:0]        ch_id,
        input logic [RPM_W-1:0]  rpm,
        input logic [DUTY_W-1:0] duty,
        input logic [2:0]        idx
    );
        logic [7:0] rpm_hi;
        logic [7:0] csum;
        logic [7:0] b;
        rpm_hi = {7'b0, rpm[8]};
        csum   = ch_id ^ rpm_hi ^ rpm[7:0] ^ duty[15:8] ^ duty[7:0];
        case (idx)
            3'd0:    b = hdr;
            3'd1:    b = ch_id;
            3'd2:    b = rpm_hi;
            3'd3:    b = rpm[7:0];
            3'd4:    b = duty[15:8];
            3'd5:    b = duty[7:0];
            default: b = csum;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running period counter; tick pulses for one cycle on the last count before wrap.
// Tick is a decode of the counter register, so it lands in the same cycle the counter reads PERIOD_CLKS-1.
module frame_tick_gen #(
    parameter int PERIOD_CLKS = 1250000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CLKS - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/telemetry_scheduler.sv
// Periodic telemetry framer: snapshots all channels' rpm/duty on a tick and streams 7-byte frames to uart_tx.
// First start_tx 3 cycles after tick; one byte in flight, paced by tx_done; ticks while busy are dropped and counted.
module telemetry_scheduler
    import telemetry_pkg::*;
#(
    parameter int         N_CH        = 2,
    parameter int         PERIOD_CLKS = 1250000,
    parameter logic [7:0] HEADER      = HEADER_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_en,
    input  logic                    dtr,
    input  logic [N_CH*RPM_W-1:0]   rpm_in,
    input  logic [N_CH*DUTY_W-1:0]  duty_in,
    output logic                    start_tx,
    output logic [7:0]              tx_byte,
    input  logic                    tx_done,
    output logic                    busy,
    output logic [15:0]             frames_sent,
    output logic [7:0]              overrun_cnt
);
    localparam int              CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [2:0]      LAST_BYTE = 3'(FRAME_BYTES - 1);
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(N_CH - 1);

    state_t                   r_state;
    logic [N_CH*RPM_W-1:0]    r_rpm;
    logic [N_CH*DUTY_W-1:0]   r_duty;
    logic [CH_W-1:0]          r_ch;
    logic [2:0]               r_byte;
    logic                     r_start_tx;
    logic [7:0]               r_tx_byte;
    logic                     r_busy;
    logic [15:0]              r_frames;
    logic [7:0]               r_ovr;

    logic                     w_tick;
    logic                     w_abort;
    logic [RPM_W-1:0]         w_rpm;
    logic [DUTY_W-1:0]        w_duty;
    logic [7:0]               w_byte;

    frame_tick_gen #(
        .PERIOD_CLKS(PERIOD_CLKS)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_rpm   = r_rpm[r_ch*RPM_W +: RPM_W];
    assign w_duty  = r_duty[r_ch*DUTY_W +: DUTY_W];
    assign w_byte  = frame_byte(HEADER, 8'(r_ch), w_rpm, w_duty, r_byte);
    assign w_abort = !uart_en || dtr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_rpm      <= '0;
            r_duty     <= '0;
            r_ch       <= '0;
            r_byte     <= '0;
            r_start_tx <= 1'b0;
            r_tx_byte  <= '0;
            r_busy     <= 1'b0;
            r_frames   <= '0;
            r_ovr      <= '0;
        end else begin
            r_start_tx <= 1'b0;
            // A tick that finds a frame in progress is dropped, never queued.
            if (w_tick && (r_state != IDLE) && (r_ovr != 8'hFF)) begin
                r_ovr <= r_ovr + 8'd1;
            end
            case (r_state)
                IDLE: begin
                    if (w_tick && uart_en && !dtr) begin
                        r_state <= SNAP;
                        r_busy  <= 1'b1;
                    end
                end
                SNAP: begin
                    r_rpm   <= rpm_in;
                    r_duty  <= duty_in;
                    r_ch    <= '0;
                    r_byte  <= '0;
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_tx_byte  <= w_byte;
                    r_start_tx <= 1'b1;
                    r_state    <= START;
                end
                START: begin
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        r_state <= NEXT;
                    end
                end
                NEXT: begin
                    if (r_byte != LAST_BYTE) begin
                        r_byte <= r_byte + 3'd1;
                        if (w_abort) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= LOAD;
                        end
                    end else begin
                        // Completed frames always count, even if the link drops right here.
                        r_frames <= r_frames + 16'd1;
                        r_byte   <= '0;
                        if ((r_ch == LAST_CH) || w_abort) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_ch    <= r_ch + CH_W'(1);
                            r_state <= LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign start_tx    = r_start_tx;
    assign tx_byte     = r_tx_byte;
    assign busy        = r_busy;
    assign frames_sent = r_frames;
    assign overrun_cnt = r_ovr;

endmodule
